// File: rtl/seq_fixed_point_square.sv
// Iterative signed fixed-point squarer: out = in*in, one shift-add step per input bit,
// with a valid/ready handshake on both sides.
module seq_fixed_point_square #(
    parameter int unsigned WII   = 8,
    parameter int unsigned WIF   = 8,
    parameter int unsigned WOI   = 8,
    parameter int unsigned WOF   = 8,
    parameter int unsigned ROOF  = 1,
    parameter int unsigned ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WII+WIF-1:0]   in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 upflow,
    output logic                 downflow
);

    localparam int unsigned W    = WII + WIF;
    localparam int unsigned AW   = 2 * W;
    localparam int unsigned WO   = WOI + WOF;
    localparam int unsigned IW   = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned DROP = (2 * WIF > WOF) ? (2 * WIF - WOF) : 0;
    localparam int unsigned LSH  = (2 * WIF <= WOF) ? (WOF - 2 * WIF) : 0;
    localparam int unsigned RIDX = (DROP > 0) ? (DROP - 1) : 0;
    localparam int unsigned SWA  = AW + 1 + LSH;
    localparam int unsigned SW   = (SWA > WO + 1) ? SWA : (WO + 1);
    localparam logic [WO-1:0] MAXP = {1'b0, {(WO - 1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    m_q, m_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   i_q, i_d;
    logic [WO-1:0]   out_q, out_d;
    logic            upflow_q, upflow_d;
    logic            downflow_q, downflow_d;
    logic            valid_q, valid_d;

    logic [SW-1:0]   acc_ext;
    logic [SW-1:0]   scaled;
    logic            rnd_bit;
    logic            sat;

    // Rescale the 2*WIF-fraction product to WOF fraction bits and detect overflow.
    always_comb begin
        acc_ext = SW'(acc_q);
        rnd_bit = ((ROUND != 0) && (DROP > 0)) ? acc_q[RIDX] : 1'b0;
        scaled  = ((acc_ext >> DROP) << LSH) + SW'(rnd_bit);
        sat     = (scaled > SW'(MAXP));
    end

    // Next-state and datapath updates for the IDLE/CALC/FIN/DONE sequence.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        acc_d      = acc_q;
        i_d        = i_q;
        out_d      = out_q;
        upflow_d   = upflow_q;
        downflow_d = downflow_q;
        valid_d    = valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Magnitude of the most negative value still fits W unsigned bits.
                    m_d     = in[W-1] ? (~in + W'(1)) : in;
                    acc_d   = '0;
                    i_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (m_q[i_q]) begin
                    acc_d = acc_q + (AW'(m_q) << i_q);
                end
                i_d = i_q + IW'(1);
                if (i_q == IW'(W - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (sat && (ROOF != 0)) begin
                    out_d = MAXP;
                end else begin
                    out_d = scaled[WO-1:0];
                end
                upflow_d   = sat;
                downflow_d = (m_q != '0) && (scaled == '0);
                valid_d    = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            acc_q      <= '0;
            i_q        <= '0;
            out_q      <= '0;
            upflow_q   <= 1'b0;
            downflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            acc_q      <= acc_d;
            i_q        <= i_d;
            out_q      <= out_d;
            upflow_q   <= upflow_d;
            downflow_q <= downflow_d;
            valid_q    <= valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = valid_q;
    assign out       = out_q;
    assign upflow    = upflow_q;
    assign downflow  = downflow_q;

endmodule

// File: tb/tb_seq_fixed_point_square.sv
// Bench for seq_fixed_point_square: two instances (saturate+round, wrap+truncate) share
// stimulus; a cycle-level reference model is checked on every negative edge.
module tb_seq_fixed_point_square;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_d = '0;

    logic        in_ready_a, out_valid_a, up_a, dn_a;
    logic [15:0] out_a;
    logic        in_ready_b, out_valid_b, up_b, dn_b;
    logic [15:0] out_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_fixed_point_square #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .ROOF(1), .ROUND(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in(in_d),
        .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a),
        .upflow(up_a), .downflow(dn_a)
    );

    seq_fixed_point_square #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .ROOF(0), .ROUND(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in(in_d),
        .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b),
        .upflow(up_b), .downflow(dn_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact square in units of 2^-16, requantised to 2^-8, then range-checked.
    function automatic logic [17:0] model(input logic [15:0] x, input bit roof, input bit rnd);
        longint v;
        longint sq;
        longint q;
        bit     up;
        bit     dn;
        logic [15:0] o;
        v  = longint'($signed(x));
        sq = v * v;
        q  = rnd ? (sq + 128) / 256 : sq / 256;
        up = (q > 32767);
        dn = (v != 0) && (q == 0);
        o  = (up && roof) ? 16'h7FFF : 16'(q);
        return {up, dn, o};
    endfunction

    // Cycle-level expectation: busy for W+1 cycles after acceptance, then result held.
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_cnt   = 0;
    logic [17:0] exp_a   = '0;
    logic [17:0] exp_b   = '0;
    int          n_accept = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (!m_busy && in_valid) begin
            m_busy   <= 1'b1;
            m_cnt    <= W + 1;
            exp_a    <= model(in_d, 1'b1, 1'b1);
            exp_b    <= model(in_d, 1'b0, 1'b0);
            n_accept <= n_accept + 1;
        end else if (m_busy && m_cnt > 0) begin
            m_cnt   <= m_cnt - 1;
            m_valid <= (m_cnt == 1);
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        check("in_ready_a", 32'(in_ready_a), 32'(!m_busy && !rst));
        check("in_ready_b", 32'(in_ready_b), 32'(!m_busy && !rst));
        check("out_valid_a", 32'(out_valid_a), 32'(m_valid));
        check("out_valid_b", 32'(out_valid_b), 32'(m_valid));
        if (m_valid) begin
            check("result_a", 32'({up_a, dn_a, out_a}), 32'(exp_a));
            check("result_b", 32'({up_b, dn_b, out_b}), 32'(exp_b));
            check("flags_excl_a", 32'(up_a && dn_a), 32'(0));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One directed operation with literal expectations, latency check and a 5-cycle stall.
    task automatic run_op(input string name, input logic [15:0] x,
                          input logic [17:0] lit_a, input logic [17:0] lit_b);
        int t;
        int lat;
        in_d = x;
        in_valid = 1'b1;
        out_ready = 1'b0;
        t = 0;
        while (!in_ready_a && t < 100) begin
            step();
            t++;
        end
        check({name, "_accept_timeout"}, 32'(t < 100), 32'(1));
        step();
        in_valid = 1'b0;
        in_d = 16'($urandom);
        lat = 0;
        while (!out_valid_a && lat < 100) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(W + 1));
        for (int s = 0; s < 5; s++) begin
            check({name, "_lit_a"}, 32'({up_a, dn_a, out_a}), 32'(lit_a));
            check({name, "_lit_b"}, 32'({up_b, dn_b, out_b}), 32'(lit_b));
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_consumed"}, 32'(out_valid_a), 32'(0));
    endtask

    initial begin
        // Pin the reference model to hand-computed values.
        check("model_3p0",   32'(model(16'h0300, 1'b1, 1'b1)), 32'(18'h00900));
        check("model_m2p5",  32'(model(16'hFD80, 1'b1, 1'b1)), 32'(18'h00640));
        check("model_sat",   32'(model(16'h8000, 1'b1, 1'b1)), 32'(18'h27FFF));
        check("model_wrap",  32'(model(16'h8000, 1'b0, 1'b0)), 32'(18'h20000));
        check("model_rnd_c", 32'(model(16'h000C, 1'b1, 1'b1)), 32'(18'h00001));
        check("model_trn_c", 32'(model(16'h000C, 1'b0, 1'b0)), 32'(18'h10000));

        rst = 1'b1;
        repeat (3) step();
        check("reset_out_a", 32'({out_valid_a, up_a, dn_a, out_a}), 32'(0));
        check("reset_out_b", 32'({out_valid_b, up_b, dn_b, out_b}), 32'(0));
        rst = 1'b0;
        #1;

        run_op("sq_3p0",   16'h0300, 18'h00900, 18'h00900);
        run_op("sq_m2p5",  16'hFD80, 18'h00640, 18'h00640);
        run_op("sq_min",   16'h8000, 18'h27FFF, 18'h20000);
        run_op("sq_0x0b",  16'h000B, 18'h10000, 18'h10000);
        run_op("sq_0x0c",  16'h000C, 18'h00001, 18'h10000);
        run_op("sq_zero",  16'h0000, 18'h00000, 18'h00000);

        // Back-to-back: one result per W+3 cycles with both valids held high.
        begin
            int start_acc;
            start_acc = n_accept;
            in_valid = 1'b1;
            out_ready = 1'b1;
            for (int c = 0; c < 190; c++) begin
                in_d = 16'($urandom);
                step();
            end
            in_valid = 1'b0;
            check("throughput_accepts", 32'(n_accept - start_acc), 32'(10));
            repeat (W + 4) step();
            out_ready = 1'b0;
        end

        // Reset during CALC aborts the operation.
        in_d = 16'h0300;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        check("abort_outputs_a", 32'({out_valid_a, up_a, dn_a, out_a}), 32'(0));
        check("abort_in_ready",  32'(in_ready_a), 32'(0));
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(in_ready_a), 32'(1));
        run_op("sq_1p0", 16'h0100, 18'h00100, 18'h00100);

        // Randomized traffic with stalls, edge operands and occasional resets.
        for (int c = 0; c < 5000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 799) == 0);
            case ($urandom_range(0, 5))
                0:       in_d = 16'h8000;
                1:       in_d = 16'($urandom_range(0, 31));
                2:       in_d = 16'(-$signed(17'($urandom_range(0, 31))));
                3:       in_d = 16'h7FFF;
                default: in_d = 16'($urandom);
            endcase
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
